mem_access_stage: RTL and testbench

//  EX/MEM pipeline register plus data-memory access unit; sits between the execute stage and the MEM/WB register.

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/dmem_access_fsm.sv | 88 ++++++++
 rtl/mem_access_stage.sv | 99 +++++++++
 tb/tb_mem_access_stage.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared constants for the EX/MEM stage: access FSM state codes and WB/M control bit positions.
package pipeline_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;

  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned M_READ      = 0;
  localparam int unsigned M_WRITE     = 1;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack port; the stage is the master, the memory is the slave.
interface mem_access_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/dmem_access_fsm.sv
// Load/store sequencer: IDLE -> ACCESS (req held until ack) -> COMPLETE, captures load data.
// With DMEM_TIMEOUT_EN defined, an access without ack is aborted after TIMEOUT_CYCLES cycles.
module dmem_access_fsm
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_mem,
  input  logic              is_load,
  input  logic              is_store,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [1:0]        state,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] rdata,
  output logic              squash,
  output logic              err
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] rdata_q;
  logic              timeout_hit;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            squash_q;
  logic            err_q;

  assign timeout_hit = (state_q == ACCESS) && !dmem_ack &&
                       (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Counter is zero on the first ACCESS cycle, so the abort lands after TIMEOUT_CYCLES req cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      squash_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q <= (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
      if (timeout_hit) begin
        squash_q <= 1'b1;
        err_q    <= 1'b1;
      end else if (state_q == COMPLETE) begin
        squash_q <= 1'b0;
      end
    end
  end

  assign squash = squash_q;
  assign err    = err_q;
`else
  assign timeout_hit = 1'b0;
  assign squash      = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (is_mem) state_d = ACCESS;
      ACCESS:   if (dmem_ack || timeout_hit) state_d = COMPLETE;
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == ACCESS) && dmem_ack && is_load) rdata_q <= dmem_rdata;
    end
  end

  assign state    = state_q;
  assign dmem_req = (state_q == ACCESS);
  assign dmem_we  = is_store;
  assign rdata    = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register plus data-memory access; stalls upstream while a load/store is in flight.
// Optional DMEM_TIMEOUT_EN aborts accesses that never see an ack and raises sticky err_o.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned REG_AW         = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          WB,
  input  logic [1:0]          M,
  input  logic                ex_valid,
  input  logic                flush,
  input  logic [DATA_W-1:0]   ALUresult,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [REG_AW-1:0]   DirWriteReg,
  mem_access_stage_if.master  dmem,
  output logic                stall_o,
  output logic [1:0]          O_WB,
  output logic [DATA_W-1:0]   O_ReadData,
  output logic [DATA_W-1:0]   O_ALUresult,
  output logic [REG_AW-1:0]   O_DirWriteReg,
  output logic                err_o
);

  logic              valid_q;
  logic [1:0]        wb_q, m_q;
  logic [DATA_W-1:0] alu_q, wdata_q;
  logic [REG_AW-1:0] dir_q;

  logic              is_mem, is_load, is_store, squash, out_valid;
  logic [1:0]        state;
  logic [DATA_W-1:0] rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wb_q    <= '0;
      m_q     <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      dir_q   <= '0;
    end else if (!stall_o) begin
      if (flush || !ex_valid) begin
        valid_q <= 1'b0;
        wb_q    <= '0;
        m_q     <= '0;
        alu_q   <= '0;
        wdata_q <= '0;
        dir_q   <= '0;
      end else begin
        valid_q <= 1'b1;
        wb_q    <= WB;
        m_q     <= M;
        alu_q   <= ALUresult;
        wdata_q <= WriteData;
        dir_q   <= DirWriteReg;
      end
    end
  end

  // M=2'b11 counts as a store, so a load needs MemWrite clear.
  assign is_mem   = valid_q & (m_q[M_READ] | m_q[M_WRITE]);
  assign is_store = m_q[M_WRITE];
  assign is_load  = m_q[M_READ] & ~m_q[M_WRITE];
  assign stall_o  = is_mem & (state != COMPLETE);

  dmem_access_fsm #(
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .is_mem     (is_mem),
    .is_load    (is_load),
    .is_store   (is_store),
    .dmem_ack   (dmem.dmem_ack),
    .dmem_rdata (dmem.dmem_rdata),
    .state      (state),
    .dmem_req   (dmem.dmem_req),
    .dmem_we    (dmem.dmem_we),
    .rdata      (rdata),
    .squash     (squash),
    .err        (err_o)
  );

  assign dmem.dmem_addr  = alu_q;
  assign dmem.dmem_wdata = wdata_q;

  // MEM/WB has no enable, so anything not yet complete is presented as a bubble.
  assign out_valid     = valid_q & (~is_mem | (state == COMPLETE)) & ~squash;
  assign O_WB          = out_valid ? wb_q : 2'b00;
  assign O_DirWriteReg = out_valid ? dir_q : '0;
  assign O_ReadData    = (out_valid & is_load) ? rdata : '0;
  assign O_ALUresult   = alu_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus scoreboard of expected MEM/WB outputs.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WB, M;
  logic        ex_valid, flush;
  logic [31:0] ALUresult, WriteData;
  logic [4:0]  DirWriteReg;
  logic        stall_o, err_o;
  logic [1:0]  O_WB;
  logic [31:0] O_ReadData, O_ALUresult;
  logic [4:0]  O_DirWriteReg;

  mem_access_stage_if #(.DATA_W(32)) dmem ();

  mem_access_stage #(
    .DATA_W         (32),
    .REG_AW         (5),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .WB            (WB),
    .M             (M),
    .ex_valid      (ex_valid),
    .flush         (flush),
    .ALUresult     (ALUresult),
    .WriteData     (WriteData),
    .DirWriteReg   (DirWriteReg),
    .dmem          (dmem),
    .stall_o       (stall_o),
    .O_WB          (O_WB),
    .O_ReadData    (O_ReadData),
    .O_ALUresult   (O_ALUresult),
    .O_DirWriteReg (O_DirWriteReg),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, fl;
    logic [1:0]  wb, m;
    logic [31:0] alu, wd;
    logic [4:0]  dir;
    int          lat;
    logic [31:0] rd;
    logic [1:0]  exp_wb;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd, alu;
    logic [4:0]  dir;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cur_lat = 1;
  logic [31:0] cur_rdata = '0;
  logic        mem_en = 1'b1;
  int          req_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: ack in the cur_lat-th consecutive req cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mem_en) begin
        if (dmem.dmem_req) begin
          if (req_cycles + 1 >= cur_lat) begin
            dmem.dmem_ack   = 1'b1;
            dmem.dmem_rdata = cur_rdata;
            req_cycles      = 0;
          end else begin
            dmem.dmem_ack = 1'b0;
            req_cycles++;
          end
        end else begin
          dmem.dmem_ack = 1'b0;
          req_cycles    = 0;
        end
      end
    end
  end

  // Scoreboard: every non-bubble MEM/WB output must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && O_WB != 2'b00) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_wb", {30'd0, O_WB}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_wb", {30'd0, O_WB}, {30'd0, e.wb});
        chk("sb_rdata", O_ReadData, e.rd);
        chk("sb_alu", O_ALUresult, e.alu);
        chk("sb_dir", {27'd0, O_DirWriteReg}, {27'd0, e.dir});
      end
    end
  end

  // Present one instruction, wait out its stall, check completion-cycle outputs.
  task automatic issue(input vec_t t, input logic flush_in_stall);
    int   n;
    exp_t e;
    WB          = t.wb;
    M           = t.m;
    ex_valid    = t.v;
    flush       = t.fl;
    ALUresult   = t.alu;
    WriteData   = t.wd;
    DirWriteReg = t.dir;
    cur_lat     = t.lat;
    cur_rdata   = t.rd;
    if (t.exp_wb != 2'b00) begin
      e.wb  = t.exp_wb;
      e.rd  = t.exp_rd;
      e.alu = t.alu;
      e.dir = t.dir;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (flush_in_stall) begin
      flush     = 1'b1;
      ex_valid  = 1'b1;
      WB        = 2'b10;
      M         = 2'b00;
      ALUresult = 32'h999;
    end else begin
      ex_valid = 1'b0;
      flush    = 1'b0;
    end
    if (t.exp_stall > 0) chk("cycle0_bubble", {30'd0, O_WB}, 32'd0);
    n = 0;
    while (stall_o && n < 100) begin
      if (dmem.dmem_req) begin
        chk("req_addr", dmem.dmem_addr, t.alu);
        chk("req_wdata", dmem.dmem_wdata, t.wd);
        chk("req_we", {31'd0, dmem.dmem_we}, {31'd0, t.m[1]});
      end
      n++;
      @(posedge clk);
      #1;
    end
    chk("stall_cycles", n, t.exp_stall);
    chk("done_wb", {30'd0, O_WB}, {30'd0, t.exp_wb});
    chk("done_rdata", O_ReadData, t.exp_rd);
  endtask

  vec_t vecs[9];

  initial begin
    int   n;
    vec_t t;
    vecs[0] = '{1'b1, 1'b0, 2'b10, 2'b00, 32'h40,  32'h0,        5'd8,  1, 32'h0,
                2'b10, 32'h0, 0};
    vecs[1] = '{1'b1, 1'b0, 2'b11, 2'b01, 32'h100, 32'h0,        5'd3,  3, 32'hDEADBEEF,
                2'b11, 32'hDEADBEEF, 4};
    vecs[2] = '{1'b1, 1'b0, 2'b00, 2'b10, 32'h200, 32'h12345678, 5'd0,  2, 32'hFFFF0000,
                2'b00, 32'h0, 3};
    vecs[3] = '{1'b1, 1'b0, 2'b11, 2'b01, 32'h104, 32'h0,        5'd4,  1, 32'hA5A50001,
                2'b11, 32'hA5A50001, 2};
    vecs[4] = '{1'b1, 1'b0, 2'b11, 2'b01, 32'h108, 32'h0,        5'd5,  1, 32'h00001234,
                2'b11, 32'h00001234, 2};
    vecs[5] = '{1'b0, 1'b0, 2'b10, 2'b00, 32'h50,  32'h0,        5'd6,  1, 32'h0,
                2'b00, 32'h0, 0};
    vecs[6] = '{1'b1, 1'b1, 2'b11, 2'b01, 32'h60,  32'h0,        5'd7,  1, 32'h0,
                2'b00, 32'h0, 0};
    vecs[7] = '{1'b1, 1'b0, 2'b10, 2'b11, 32'h300, 32'hCAFE0000, 5'd9,  1, 32'h77777777,
                2'b10, 32'h0, 2};
    vecs[8] = '{1'b1, 1'b0, 2'b11, 2'b00, 32'h77,  32'h0,        5'd10, 1, 32'h0,
                2'b11, 32'h0, 0};

    rst = 1'b1;
    WB = '0; M = '0; ex_valid = 1'b0; flush = 1'b0;
    ALUresult = '0; WriteData = '0; DirWriteReg = '0;
    dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_wb", {30'd0, O_WB}, 32'd0);
    chk("rst_alu", O_ALUresult, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) issue(vecs[i], 1'b0);

    // Flush raised while stalled must not disturb the load; it takes effect once stall drops.
    t = vecs[1];
    t.alu = 32'h400; t.dir = 5'd12; t.rd = 32'h0BADF00D; t.exp_rd = 32'h0BADF00D;
    issue(t, 1'b1);
    @(posedge clk);
    #1;
    chk("flush_after_stall", {30'd0, O_WB}, 32'd0);
    flush    = 1'b0;
    ex_valid = 1'b0;
    @(posedge clk);
    #1;

`ifdef DMEM_TIMEOUT_EN
    mem_en = 1'b0;
    dmem.dmem_ack = 1'b0;
    WB = 2'b11; M = 2'b01; ex_valid = 1'b1; ALUresult = 32'h500; DirWriteReg = 5'd13;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    n = 0;
    begin
      int rq;
      rq = 0;
      while (stall_o && n < 100) begin
        if (dmem.dmem_req) rq++;
        n++;
        @(posedge clk);
        #1;
      end
      chk("to_req_cycles", rq, 16);
    end
    chk("to_stall_cycles", n, 17);
    chk("to_req_dropped", {31'd0, dmem.dmem_req}, 32'd0);
    chk("to_wb_squash", {30'd0, O_WB}, 32'd0);
    chk("to_err", {31'd0, err_o}, 32'd1);
    mem_en = 1'b1;
    issue(vecs[0], 1'b0);
    chk("to_err_sticky", {31'd0, err_o}, 32'd1);
`endif

    // Reset while the request is outstanding; a stale ack afterwards must be ignored.
    mem_en = 1'b0;
    dmem.dmem_ack = 1'b0;
    WB = 2'b11; M = 2'b01; ex_valid = 1'b1; ALUresult = 32'h600; DirWriteReg = 5'd14;
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_rst_req", {31'd0, dmem.dmem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("mid_rst_wb", {30'd0, O_WB}, 32'd0);
    chk("mid_rst_err", {31'd0, err_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    dmem.dmem_ack   = 1'b1;
    dmem.dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    dmem.dmem_ack = 1'b0;
    chk("stale_ack_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("stale_ack_stall", {31'd0, stall_o}, 32'd0);
    chk("stale_ack_wb", {30'd0, O_WB}, 32'd0);
    chk("stale_ack_rdata", O_ReadData, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
`ifndef DMEM_TIMEOUT_EN
    chk("err_tied_low", {31'd0, err_o}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
